// File: rtl/sd_pkg.sv
// Shared definitions for the 1011 sync-word link: transmitter state encoding,
// default sync word, and the bit-counter width helper.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } sd_tx_state_t;

  localparam int SYNC_W_DEFAULT = 4;
  localparam logic [SYNC_W_DEFAULT-1:0] SYNC_PATTERN_DEFAULT = 4'b1011;

  // Counter must hold (longest phase - 1); never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sd_tx_shifter.sv
// Parallel-load, MSB-first shift register for the frame payload.
// With SD_TX_PARITY_EN defined it also captures even parity of the loaded word.
module sd_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
`ifdef SD_TX_PARITY_EN
  output logic              parity,
`endif
  output logic              serial_out
);

  logic [DATA_W-1:0] shift_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= data;
    end else if (shift) begin
      shift_reg <= shift_reg << 1;
    end
  end

  assign serial_out = shift_reg[DATA_W-1];

`ifdef SD_TX_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity_reg <= 1'b0;
    end else if (load) begin
      parity_reg <= ^data;
    end
  end

  assign parity = parity_reg;
`endif

endmodule

// File: rtl/sd_frame_tx.sv
// Serial frame transmitter: sync word, MSB-first payload, optional even parity
// bit (SD_TX_PARITY_EN), then a forced idle gap. One bit per clock.
module sd_frame_tx
  import sd_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
  parameter int                GAP_CYCLES   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sequence_out,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int CNT_W = cnt_width(SYNC_W, DATA_W, GAP_CYCLES);
  localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  sd_tx_state_t      state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_dec;
  logic              line_reg, line_next;
  logic              load, shift, serial_out;
  logic [SYNC_W-1:0] sync_sel;

`ifdef SD_TX_PARITY_EN
  logic parity;
`endif

  sd_tx_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .shift      (shift),
    .data       (tx_data),
`ifdef SD_TX_PARITY_EN
    .parity     (parity),
`endif
    .serial_out (serial_out)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      line_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      line_reg  <= line_next;
    end
  end

  assign cnt_dec  = cnt_reg - CNT_W'(1);
  assign sync_sel = SYNC_PATTERN >> cnt_dec;

  // line_next is the bit the line carries in the cycle after this edge, so the
  // first sync bit appears right after the accept edge with no extra stage.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    line_next  = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tx_valid) begin
          state_next = ST_SYNC;
          cnt_next   = SYNC_LOAD;
          line_next  = SYNC_PATTERN[SYNC_W-1];
          load       = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cnt_reg == '0) begin
          state_next = ST_PAYLOAD;
          cnt_next   = DATA_LOAD;
          line_next  = serial_out;
          shift      = 1'b1;
        end else begin
          cnt_next  = cnt_dec;
          line_next = sync_sel[0];
        end
      end
      ST_PAYLOAD: begin
        if (cnt_reg == '0) begin
`ifdef SD_TX_PARITY_EN
          state_next = ST_PARITY;
          cnt_next   = '0;
          line_next  = parity;
`else
          state_next = ST_GAP;
          cnt_next   = GAP_LOAD;
`endif
        end else begin
          cnt_next  = cnt_dec;
          line_next = serial_out;
          shift     = 1'b1;
        end
      end
`ifdef SD_TX_PARITY_EN
      ST_PARITY: begin
        state_next = ST_GAP;
        cnt_next   = GAP_LOAD;
      end
`endif
      ST_GAP: begin
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign sequence_out = line_reg;
  assign tx_ready     = (state_reg == ST_IDLE);
  assign tx_busy      = (state_reg != ST_IDLE);
  assign frame_done   = (state_reg == ST_GAP) && (cnt_reg == GAP_LOAD);

endmodule

// File: tb/tb_sd_frame_tx.sv
// Self-checking bench for sd_frame_tx: directed and randomized frames compared
// against a bit-queue frame model and a window-based 1011 detector model.
module tb_sd_frame_tx;

  localparam int SYNC_W = 4;
  localparam int DATA_W = 8;
  localparam int GAP    = 2;
`ifdef SD_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int PERIOD = 1 + SYNC_W + DATA_W + P + GAP;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, sequence_out, tx_busy, frame_done;

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  logic [3:0] sp;
  logic [3:0] win = '0;
  int     det_count = 0;
  int     det_badpos = 0;

  sd_frame_tx dut (
    .clock        (clock),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .sequence_out (sequence_out),
    .tx_busy      (tx_busy),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Send one frame and check every line bit; hold keeps tx_valid high so the
  // next word (d_after) is offered straight away at the following IDLE cycle.
  task automatic run_frame(input logic [7:0] d, input bit hold, input logic [7:0] d_after,
                           input bit scramble, output longint t0);
    bit exp_q[$];
    int budget;
    budget = 0;
    while (tx_ready !== 1'b1 && budget < 40) begin
      @(negedge clock);
      budget++;
    end
    check("ready_wait", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clock);
    t0 = cyc;
    tx_valid = hold;
    if (hold) tx_data = d_after;
    exp_q = {};
    for (int i = SYNC_W - 1; i >= 0; i--) exp_q.push_back(sp[i]);
    for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(d[i]);
    if (P == 1) exp_q.push_back(^d);
    for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("line d=%02h bit%0d", d, i), sequence_out, exp_q[i]);
      check($sformatf("busy bit%0d", i), tx_busy, 1'b1);
      check($sformatf("ready bit%0d", i), tx_ready, 1'b0);
      check($sformatf("done bit%0d", i), frame_done, (i == SYNC_W + DATA_W + P));
      win = {win[2:0], sequence_out};
      if (win == 4'b1011) begin
        det_count++;
        if (i != SYNC_W - 1) det_badpos++;
      end
      if (scramble) tx_data = 8'($urandom);
      @(negedge clock);
    end
    check("idle ready", tx_ready, 1'b1);
    check("idle busy", tx_busy, 1'b0);
    check("idle line", sequence_out, 1'b0);
    check("idle done", frame_done, 1'b0);
    check("detector zero at idle", win[1:0], 2'b00);
    win = {win[2:0], sequence_out};
  endtask

  initial begin
    longint t_a, t_b, t_prev;
    logic [7:0] d, nxt;
    bit held, h;
    sp = 4'b1011;
    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clock);
    check("rst line", sequence_out, 1'b0);
    check("rst ready", tx_ready, 1'b1);
    check("rst busy", tx_busy, 1'b0);
    check("rst done", frame_done, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check("idle no valid busy", tx_busy, 1'b0);

    run_frame(8'hA5, 1'b0, 8'h00, 1'b0, t_a);
    run_frame(8'h07, 1'b0, 8'h00, 1'b0, t_a);

    // back-to-back: word offered during busy is taken at the next IDLE
    run_frame(8'h00, 1'b1, 8'hFF, 1'b0, t_a);
    run_frame(8'hFF, 1'b0, 8'h00, 1'b0, t_b);
    check("period", 32'(t_b - t_a), PERIOD);

    // asynchronous reset in the middle of payload bit 3
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (SYNC_W + 3) @(negedge clock);
    check("c3 bit3 before reset", sequence_out, 1'(8'hC3 >> (DATA_W - 1 - 3)));
    #2 reset = 1'b0;
    #1;
    check("async rst line", sequence_out, 1'b0);
    check("async rst busy", tx_busy, 1'b0);
    check("async rst ready", tx_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post rst ready", tx_ready, 1'b1);
    win = '0;
    run_frame(8'h81, 1'b0, 8'h00, 1'b0, t_a);

    // input changes after accept must not reach the line
    run_frame(8'h3C, 1'b0, 8'h00, 1'b1, t_a);

    // loopback against the 1011 detector model
    det_count = 0;
    det_badpos = 0;
    for (int k = 0; k < 10; k++) run_frame(8'h00, 1'b0, 8'h00, 1'b0, t_a);
    check("detections", det_count, 10);
    check("detection position", det_badpos, 0);

    // randomized frames, some back-to-back
    held = 1'b0;
    nxt = '0;
    t_prev = 0;
    for (int k = 0; k < 12; k++) begin
      d = held ? nxt : 8'($urandom);
      h = (k == 11) ? 1'b0 : 1'($urandom_range(0, 1));
      nxt = 8'($urandom);
      run_frame(d, h, nxt, !h && ($urandom_range(0, 1) == 1), t_a);
      if (held) check("rand period", 32'(t_a - t_prev), PERIOD);
      t_prev = t_a;
      held = h;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_frame_tx.md
Name: sd_frame_tx

Overview:
Serial frame transmitter, the sending end of the 1011 sync-word link. Accepts a parallel payload word over a valid/ready handshake. Emits on one serial line, one bit per clock: the sync word, then the payload MSB-first, then a guaranteed idle gap. The gap returns any downstream 1011 Moore detector to its Zero state before the next frame. Drives the `sequence_in` of the receiving detector.

Parameters:
- DATA_W, 8: payload width in bits; minimum 1.
- SYNC_W, 4: sync word width in bits.
- SYNC_PATTERN, 4'b1011: sync word, sent MSB first.
- GAP_CYCLES, 2: idle-level bits forced after each frame; minimum 2.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_W  payload word; sampled only on the accept edge.
- tx_valid  in  1  payload word offered.
- tx_ready  out  1  block can accept a word this cycle.
- sequence_out  out  1  registered serial line.
- tx_busy  out  1  frame in progress (SYNC, PAYLOAD, PARITY or GAP).
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, sequence_out=0, tx_ready=1, tx_busy=0, frame_done=0, shift and bit counters cleared.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- States are IDLE, SYNC, PAYLOAD, PARITY (only with feature), GAP.
- IDLE:
  - tx_ready=1, sequence_out=0.
  - Accept occurs when tx_valid=1 at a rising edge. tx_data is latched into the shift register and the state goes to SYNC.
  - tx_valid=0 stays in IDLE.
- SYNC: SYNC_W cycles, driving SYNC_PATTERN[SYNC_W-1] down to [0]. The first sync bit appears the cycle immediately after the accept edge.
- PAYLOAD: DATA_W cycles, driving the latched word MSB-first. Then go to PARITY if enabled, else GAP.
- GAP:
  - GAP_CYCLES cycles with sequence_out=0.
  - frame_done=1 during the first GAP cycle only.
  - Then go to IDLE.
- tx_ready=0 in every state except IDLE. tx_valid outside IDLE is ignored and does not queue.
- Changes to tx_data after the accept edge have no effect on the frame in flight.
- Frame period with tx_valid held high = 1 (IDLE) + SYNC_W + DATA_W + P + GAP_CYCLES, where P=1 with parity enabled, else 0. Defaults give 15 cycles without parity, 16 with.
- Bit counter:
  - Width is clog2(max(SYNC_W, DATA_W, GAP_CYCLES)).
  - Reloads on each state entry and counts down.
  - Terminal count 0 triggers the transition. No wrap-around is permitted.
- Reset asserted mid-frame: the frame is aborted immediately and all outputs take their reset values. There is no resume. After deassertion the block is in IDLE with tx_ready=1.
- The payload is not scrambled or stuffed; payload-embedded 1011 may alias sync downstream. That is accepted at this level.

Optional Feature:
- Macro SD_TX_PARITY_EN.
- Defined: PARITY state inserted after PAYLOAD for one cycle, driving even parity, i.e. the XOR of all DATA_W latched bits.
- Undefined: PARITY state, parity logic and parity register are absent; PAYLOAD goes directly to GAP.

Decomposition:
- Shared package sd_pkg holds:
  - the state enum typedef (sd_tx_state_t);
  - SYNC_PATTERN_DEFAULT = 4'b1011 and SYNC_W_DEFAULT = 4, common with the detector;
  - a clog2-based counter-width function.
- One natural sub-module, sd_tx_shifter: a parallel-load, MSB-first shift register. It has load, shift and serial-out, and computes parity when the macro is defined. The FSM and counter stay in sd_frame_tx.

Test Plan:
- Reset, then tx_valid=1 with tx_data=8'hA5 for one cycle → tx_ready drops next cycle; sequence_out over 14 cycles is 1011 10100101 00; frame_done high on bit 13 only; tx_ready=1 on cycle 15.
- tx_valid held high with 8'h00 then 8'hFF → second frame's first sync bit appears exactly 15 cycles after the first's. The 8'hFF payload reads 11111111. The word presented during busy is not lost and is accepted at the next IDLE.
- reset=0 pulsed mid-PAYLOAD (payload bit 3 of 8'hC3) → sequence_out=0, tx_busy=0 and tx_ready=1 immediately (asynchronously). The next accepted word 8'h81 transmits cleanly from sync.
- tx_data changed every cycle after accepting 8'h3C → line still carries 00111100.
- Loopback to the 1011 detector with payload 8'h00, 10 frames → detector_out high exactly 10 times, each one cycle after the last sync bit; detector state is Zero at every IDLE.
- SD_TX_PARITY_EN defined:
  - 8'hA5 → parity bit 0 on line cycle 13;
  - 8'h07 → parity bit 1;
  - frame period 16.
